// File: rtl/cla_8.sv
// cla_8: 8-bit two-level carry-lookahead adder slice with block generate/propagate.
// Latency: combinational by default; 1 cycle when CLA_8_OUTPUT_REG_EN is defined.
// Backpressure: none; a new operand set is accepted every cycle (or every input change).
//
// Optional feature macro: CLA_8_OUTPUT_REG_EN (registers S/G/P, sync active-high reset to 0).
//
// Ports:
//   clk    - clock, only used with the output register stage
//   reset  - synchronous active-high reset, only used with the output register stage
//   A, B   - 8-bit operands
//   Cin    - carry into bit 0
//   S      - (A + B + Cin) mod 256
//   G, P   - block generate / propagate for a higher-level lookahead unit
module cla_8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       G,
  output logic       P
);

  // 4-bit lookahead group. Returns {pg, gg, c3, c2, c1, c0}, where c0 is the
  // group carry-in. Each carry is a flat sum of products of the group's g/p
  // and its carry-in, so no carry depends on another inside the group.
  function automatic logic [5:0] cla4(input logic [3:0] g,
                                      input logic [3:0] p,
                                      input logic       ci);
    logic c1, c2, c3, gg, pg;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pg = &p;
    return {pg, gg, c3, c2, c1, ci};
  endfunction

  logic [7:0] g_bit;
  logic [7:0] p_bit;
  logic [5:0] grp_l;
  logic [5:0] grp_h;
  logic       c4;
  logic [7:0] carry;
  logic [7:0] s_comb;
  logic       g_comb;
  logic       p_comb;

  // XOR propagate doubles as the half-sum for each bit.
  assign g_bit = A & B;
  assign p_bit = A ^ B;

  assign grp_l = cla4(g_bit[3:0], p_bit[3:0], Cin);

  // Second-level lookahead: the high group's carry-in comes from the low
  // group's GG/PG, not from its internal c3.
  assign c4    = grp_l[4] | (grp_l[5] & Cin);
  assign grp_h = cla4(g_bit[7:4], p_bit[7:4], c4);

  assign carry  = {grp_h[3:0], grp_l[3:0]};
  assign s_comb = p_bit ^ carry;
  assign g_comb = grp_h[4] | (grp_h[5] & grp_l[4]);
  assign p_comb = grp_h[5] & grp_l[5];

`ifdef CLA_8_OUTPUT_REG_EN
  logic [7:0] s_q, s_d;
  logic       g_q, g_d;
  logic       p_q, p_d;

  assign s_d = s_comb;
  assign g_d = g_comb;
  assign p_d = p_comb;

  // Reset wins over the operands captured on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= 8'h00;
      g_q <= 1'b0;
      p_q <= 1'b0;
    end else begin
      s_q <= s_d;
      g_q <= g_d;
      p_q <= p_d;
    end
  end

  assign S = s_q;
  assign G = g_q;
  assign P = p_q;
`else
  // clk/reset stay in the port list so both builds share one footprint.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  assign S = s_comb;
  assign G = g_comb;
  assign P = p_comb;
`endif

endmodule

// File: tb/tb_cla_8.sv
// tb_cla_8: self-checking bench for cla_8 using directed vectors plus a sweep.
// Works in both builds; register-stage checks are compiled with CLA_8_OUTPUT_REG_EN.
module tb_cla_8;

  logic       clk;
  logic       reset;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic       cin_r;
  logic [7:0] s_w;
  logic       g_w;
  logic       p_w;

  int n_checks;
  int n_fail;

  cla_8 dut (
    .clk   (clk),
    .reset (reset),
    .A     (a_r),
    .B     (b_r),
    .Cin   (cin_r),
    .S     (s_w),
    .G     (g_w),
    .P     (p_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive operands, then wait until the result is observable.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic c);
    a_r   = a;
    b_r   = b;
    cin_r = c;
`ifdef CLA_8_OUTPUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       g;
    logic       p;
    string      tag;
  } vec_t;

  vec_t vecs[10];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    a_r      = 8'h00;
    b_r      = 8'h00;
    cin_r    = 1'b0;

    vecs[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, "ff+00+1"};
    vecs[1] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "80+80"};
    vecs[2] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "0f+01_c4"};
    vecs[3] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b1, "aa+55+0"};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1, "aa+55+1"};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero"};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "zero+cin"};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "ff+ff+1"};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "12+34+1"};
    vecs[9] = '{8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, "f0+10_gh"};

`ifdef CLA_8_OUTPUT_REG_EN
    // Reset held for two edges with live operands: outputs must be zero.
    a_r = 8'hFF; b_r = 8'hFF; cin_r = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", {24'h0, s_w}, 32'h0);
    check("rst_g", {31'h0, g_w}, 32'h0);
    check("rst_p", {31'h0, p_w}, 32'h0);

    // Release reset, apply 12+34+1: nothing before the edge, 47 one edge later.
    reset = 1'b0;
    a_r = 8'h12; b_r = 8'h34; cin_r = 1'b1;
    #2;
    check("lat_pre_s", {24'h0, s_w}, 32'h0);
    @(posedge clk);
    #1;
    check("lat_post_s", {24'h0, s_w}, 32'h47);

    // Reset mid-stream with operands held: result discarded on the next edge.
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_s", {24'h0, s_w}, 32'h0);
    check("midrst_g", {31'h0, g_w}, 32'h0);
    check("midrst_p", {31'h0, p_w}, 32'h0);
    reset = 1'b0;
    apply(8'h80, 8'h80, 1'b0);
    check("resume_g", {31'h0, g_w}, 32'h1);
`else
    // Reset is ignored by the combinational build.
    apply(8'h12, 8'h34, 1'b1);
    check("rst_ignored_s", {24'h0, s_w}, 32'h47);
    reset = 1'b0;
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c);
      check({vecs[i].tag, "_s"}, {24'h0, s_w}, {24'h0, vecs[i].s});
      check({vecs[i].tag, "_g"}, {31'h0, g_w}, {31'h0, vecs[i].g});
      check({vecs[i].tag, "_p"}, {31'h0, p_w}, {31'h0, vecs[i].p});
    end

    // Sweep against an arithmetic reference: G is the carry-out with Cin=0,
    // P is "every bit pair differs".
    begin
      int ex_total;
      int ex_ok;
      int b_step;
      int fail_before;
      logic [8:0] sum0;
      logic [8:0] sum;
      ex_total = 0;
      ex_ok    = 0;
`ifdef CLA_8_OUTPUT_REG_EN
      b_step = 17;
`else
      b_step = 1;
`endif
      for (int a = 0; a < 256; a++) begin
        for (int b = 0; b < 256; b += b_step) begin
          for (int c = 0; c < 2; c++) begin
            apply(a[7:0], b[7:0], c[0]);
            sum0 = {1'b0, a[7:0]} + {1'b0, b[7:0]};
            sum  = sum0 + {8'h00, c[0]};
            fail_before = n_fail;
            check("sweep_s", {24'h0, s_w}, {24'h0, sum[7:0]});
            check("sweep_g", {31'h0, g_w}, {31'h0, sum0[8]});
            check("sweep_p", {31'h0, p_w}, {31'h0, ((a[7:0] ^ b[7:0]) == 8'hFF)});
            ex_total++;
            if (n_fail == fail_before) ex_ok++;
          end
        end
      end
      $display("sweep: %0d/%0d passed", ex_ok, ex_total);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
